// File: rtl/shift_sequencer.sv
// Iterative shift/rotate unit for the EX stage. It consumes the shift amount
// two bits per cycle (one bit on an odd tail), stalls the pipeline while busy,
// and pulses Done with the registered result.
module shift_sequencer #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               Start,
  input  logic               Flush,
  input  logic [1:0]         Op,
  input  logic [SHAMT_W-1:0] Shamt,
  input  logic [WIDTH-1:0]   In,
  output logic               Ready,
  output logic               Busy,
  output logic               Done,
  output logic [WIDTH-1:0]   Out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  logic [1:0]         op_q, op_d;

  logic               step_two;
  logic [WIDTH-1:0]   step_val;
  logic [SHAMT_W-1:0] rem_post;

  // One shift step on the working value; a zero remainder leaves it untouched.
  always_comb begin
    step_two = (rem_q >= SHAMT_W'(2));
    step_val = acc_q;
    rem_post = step_two ? (rem_q - SHAMT_W'(2)) : '0;
    if (rem_q != '0) begin
      case (op_q)
        2'b00: step_val = step_two ? {acc_q[WIDTH-3:0], 2'b00}
                                   : {acc_q[WIDTH-2:0], 1'b0};
        2'b01: step_val = step_two ? {2'b00, acc_q[WIDTH-1:2]}
                                   : {1'b0, acc_q[WIDTH-1:1]};
        2'b10: step_val = step_two ? {{2{acc_q[WIDTH-1]}}, acc_q[WIDTH-1:2]}
                                   : {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
        default: step_val = step_two ? {acc_q[1:0], acc_q[WIDTH-1:2]}
                                     : {acc_q[0], acc_q[WIDTH-1:1]};
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    op_d    = op_q;
    out_d   = out_q;
    if (Flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (Start) begin
            acc_d   = In;
            rem_d   = Shamt;
            op_d    = Op;
            state_d = S_SHIFT;
          end
        end
        S_SHIFT: begin
          acc_d = step_val;
          rem_d = rem_post;
          if (rem_post == '0) begin
            out_d   = step_val;
            state_d = S_DONE;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      op_q    <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
      out_q   <= out_d;
    end
  end

  // Status flags come straight from the state register.
  assign Ready = (state_q == S_IDLE);
  assign Busy  = (state_q == S_SHIFT);
  assign Done  = (state_q == S_DONE);
  assign Out   = out_q;

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle shift execution unit and its controller for the MIPS datapath, serving SLL/SRL/SRA and a rotate-right. It accepts one shift command at a time and iterates a fixed 2-bit/1-bit shift step until the requested amount is consumed. It raises `Busy` as the pipeline stall request while iterating, then presents the registered result with a one-cycle `Done` pulse. It sits beside the ALU in EX and is started by the control unit.

## Interface
- `WIDTH`, 32: data width.
- `SHAMT_W`, 5: shift-amount width; must equal log2(`WIDTH`).

Ports:
- `Clk`  in  1  rising-edge clock, single domain.
- `Reset_n`  in  1  reset, synchronous, active-low.
- `Start`  in  1  command strobe; sampled only when `Ready`=1.
- `Flush`  in  1  synchronous abort, e.g. pipeline flush.
- `Op`  in  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROTR.
- `Shamt`  in  SHAMT_W  shift amount, 0..WIDTH-1.
- `In`  in  WIDTH  operand.
- `Ready`  out  1  high in IDLE; a command can be accepted.
- `Busy`  out  1  high in SHIFT; stall request to the pipeline.
- `Done`  out  1  one-cycle pulse; `Out` was updated at the same edge.
- `Out`  out  WIDTH  result register.

## Operation
- The block has three states: IDLE, SHIFT and DONE.
- **Internal registers**
  - `acc` (WIDTH): working value.
  - `rem` (SHAMT_W): amount still to shift.
  - `op_q` (2): latched `Op`.
- **IDLE**
  - `Ready`=1.
  - If `Start`=1 and `Flush`=0: load `acc`<=`In`, `rem`<=`Shamt`, `op_q`<=`Op`, and go to SHIFT.
  - Otherwise remain in IDLE.
- **SHIFT** — each edge performs one step:
  - If `rem`>=2: shift `acc` by 2 and set `rem`<=`rem`-2.
  - If `rem`=1: shift by 1 and set `rem`<=0.
  - If `rem`=0: no change.
  - If the post-step `rem` is 0: `Out`<=post-step `acc` and go to DONE.
- **Step semantics**
  - SLL: zero fill from the LSB.
  - SRL: zero fill from the MSB.
  - SRA: fill with `acc[WIDTH-1]`.
  - ROTR: bits leaving the LSB re-enter at the MSB.
- **DONE**
  - `Done`=1 for exactly this cycle.
  - Next edge goes to IDLE unconditionally.
  - `Start` is ignored in DONE.
- **Command acceptance**
  - `Start` outside IDLE is ignored and not queued.
  - `Op`, `Shamt` and `In` may change freely after acceptance; only the latched copies are used.
- **Flush**
  - In any state, `Flush`=1 at an edge forces IDLE.
  - No `Done` pulse follows, and `Out` is unchanged.
  - `Flush`+`Start` in IDLE: `Flush` wins and nothing is accepted.
- **Output registers**
  - `Out` changes only on the SHIFT->DONE edge.
  - `Out` holds its value otherwise, including across new commands until their completion.
- **Reset**
  - When `Reset_n`=0 at an edge, from any state including mid-shift: state IDLE; `acc`, `rem`, `op_q` and `Out` are 0.
  - Reset has priority over `Flush` and `Start`.

## Timing
- **Output reset values:** `Ready`=1, `Busy`=0, `Done`=0, `Out`=0.
- **Decoding:** `Ready`, `Busy` and `Done` are decoded from the state register only, with no combinational path from inputs.
- **Step count:** N = max(1, ceil(`Shamt`/2)) cycles in SHIFT.
- **Latency:** with `Start` accepted at edge E0, `Busy`=1 for cycles E0..E0+N, and `Done`=1 with the new `Out` in the cycle after edge E0+N.
  - `Shamt`=0: N=1, so `Done` appears after edge E0+1.
  - `Shamt`=31: N=16.
- **Back-to-back:** the next command can be accepted at edge E0+N+2, the first IDLE cycle after DONE. Throughput is one command per N+2 cycles.

## Test plan
- **Two-step SLL:** SLL `In`=0x0000_0001, `Shamt`=3, `Start` at E0.
  - `Busy` is high for 2 cycles.
  - `Done` and `Out`=0x0000_0008 appear after E0+2.
  - `Ready` returns after E0+3.
- **Maximum SRA:** SRA `In`=0x8000_0000, `Shamt`=31.
  - 16 `Busy` cycles.
  - `Out`=0xFFFF_FFFF.
  - Repeat with SRL: `Out`=0x0000_0001.
- **Rotate, then zero shift:** ROTR `In`=0x0000_00F1, `Shamt`=4 gives `Out`=0x1000_000F.
  - Then SRL `In`=0xDEAD_BEEF, `Shamt`=0: `Done` after 1 SHIFT cycle with `Out`=0xDEAD_BEEF.
- **Start while busy:** SLL `Shamt`=10 on 0x1.
  - Pulse `Start` with different operands during `Busy`: they are ignored.
  - `Out`=0x0000_0400 after 5 SHIFT cycles.
  - `Start` asserted during DONE is also ignored.
- **Flush:** SLL 0x1 `Shamt`=20 after a completed result 0x1234_5678.
  - `Flush` in the 3rd SHIFT cycle gives IDLE next cycle, no `Done`, and `Out` still 0x1234_5678.
  - `Start`+`Flush` together in IDLE: no acceptance.
- **Reset mid-shift:** `Reset_n`=0 during SHIFT.
  - Next cycle: `Ready`=1, `Busy`=0, `Done`=0, `Out`=0.
  - A fresh SLL 0x3 `Shamt`=1 then yields 0x6.
